// File: rtl/sysmm_pkg.sv
// sysmm_pkg: shared constants and state encoding for the 4x4 systolic
// multiplier sequencer (systolic_mm_ctrl, sysmm_skew_mux).
package sysmm_pkg;

  localparam int unsigned N         = 4;
  localparam int unsigned DW        = 32;
  localparam int unsigned AW        = 5;
  localparam int unsigned FEED_CYC  = 3 * N - 2;
  localparam int unsigned DRAIN_CYC = N;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/sysmm_skew_mux.sv
// sysmm_skew_mux: combinational edge decode for the systolic array.
//   en_i      : 1 = FEED state, else both edges are forced to 0
//   t_i       : feed count
//   a_buf_i   : A operands, element [r][c] at bits (r*N+c)*DW +: DW
//   b_buf_i   : B operands, same layout
//   a_edge_o  : lane i = A[i][t-i] when 0 <= t-i < N, else 0
//   b_edge_o  : lane j = B[t-j][j] when 0 <= t-j < N, else 0
module sysmm_skew_mux #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 4
) (
  input  logic              en_i,
  input  logic [CW-1:0]     t_i,
  input  logic [N*N*DW-1:0] a_buf_i,
  input  logic [N*N*DW-1:0] b_buf_i,
  output logic [N*DW-1:0]   a_edge_o,
  output logic [N*DW-1:0]   b_edge_o
);

  import sysmm_pkg::*;

  int unsigned tu;

  always_comb begin
    a_edge_o = '0;
    b_edge_o = '0;
    tu       = 32'(t_i);
    if (en_i) begin
      for (int unsigned i = 0; i < N; i++) begin
        // Lane i carries diagonal element k = t - i of its row/column.
        if ((tu >= i) && ((tu - i) < N)) begin
          a_edge_o[i*DW +: DW] = a_buf_i[(i * N + (tu - i)) * DW +: DW];
          b_edge_o[i*DW +: DW] = b_buf_i[((tu - i) * N + i) * DW +: DW];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_mm_ctrl.sv
// systolic_mm_ctrl: sequencer for a 4x4 output-stationary systolic array.
//   clk, rst          : clock, synchronous active-high reset
//   ld_valid/ld_ready : operand load handshake (accepted in IDLE only)
//   ld_addr, ld_data  : 0..15 -> A row-major, 16..31 -> B row-major
//   start             : begin a run (sampled in IDLE only)
//   busy              : CLEAR, FEED or DRAIN
//   done              : one-cycle pulse, array results valid
//   pe_clr            : accumulator clear (CLEAR state or rst)
//   a_edge, b_edge    : skewed row/column operand lanes
// Optional: SYSMM_RUN_CNT_EN adds run_cnt[15:0], completed-run counter.
module systolic_mm_ctrl #(
  parameter int unsigned N  = sysmm_pkg::N,
  parameter int unsigned DW = sysmm_pkg::DW,
  parameter int unsigned AW = sysmm_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_addr,
  input  logic [DW-1:0]   ld_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            pe_clr,
  output logic [N*DW-1:0] a_edge,
  output logic [N*DW-1:0] b_edge
`ifdef SYSMM_RUN_CNT_EN
  ,
  output logic [15:0]     run_cnt
`endif
);

  import sysmm_pkg::*;

  localparam int unsigned FEED_LEN  = 3 * N - 2;
  localparam int unsigned DRAIN_LEN = N;
  localparam int unsigned CW        = $clog2(FEED_LEN);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N*N*DW-1:0]   a_buf_q, b_buf_q;

  logic                ld_fire;
  logic                ld_is_b;
  int unsigned         ld_idx;
  int unsigned         ld_off;

  // Load address decode
  always_comb begin
    ld_idx  = 32'(ld_addr);
    ld_is_b = (ld_idx >= N * N);
    ld_off  = ld_is_b ? (ld_idx - N * N) : ld_idx;
    ld_fire = ld_valid && ld_ready && (ld_off < N * N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_buf_q <= '0;
      b_buf_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ld_fire) begin
        if (ld_is_b) begin
          b_buf_q[ld_off*DW +: DW] <= ld_data;
        end else begin
          a_buf_q[ld_off*DW +: DW] <= ld_data;
        end
      end
    end
  end

  // Next state; counter restarts from 0 on every state entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = FEED;
      end
      FEED: begin
        if (cnt_q == CW'(FEED_LEN - 1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_LEN - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ld_ready = (state_q == IDLE);
    busy     = (state_q == CLEAR) || (state_q == FEED) || (state_q == DRAIN);
    done     = (state_q == DONE);
    pe_clr   = rst || (state_q == CLEAR);
  end

  sysmm_skew_mux #(
    .N  (N),
    .DW (DW),
    .CW (CW)
  ) u_skew (
    .en_i     (state_q == FEED),
    .t_i      (cnt_q),
    .a_buf_i  (a_buf_q),
    .b_buf_i  (b_buf_q),
    .a_edge_o (a_edge),
    .b_edge_o (b_edge)
  );

`ifdef SYSMM_RUN_CNT_EN
  logic [15:0] run_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= '0;
    end else if (state_q == DONE) begin
      run_cnt_q <= run_cnt_q + 16'd1;
    end
  end

  assign run_cnt = run_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
module tb_systolic_mm_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld_valid;
  logic         ld_ready;
  logic [4:0]   ld_addr;
  logic [31:0]  ld_data;
  logic         start;
  logic         busy;
  logic         done;
  logic         pe_clr;
  logic [127:0] a_edge;
  logic [127:0] b_edge;
`ifdef SYSMM_RUN_CNT_EN
  logic [15:0]  run_cnt;
`endif

  systolic_mm_ctrl #(
    .N  (4),
    .DW (32),
    .AW (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pe_clr   (pe_clr),
    .a_edge   (a_edge),
    .b_edge   (b_edge)
`ifdef SYSMM_RUN_CNT_EN
    ,
    .run_cnt  (run_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural output-stationary 4x4 array driven by the DUT edges
  logic [31:0] acc [4][4];
  logic [31:0] ar  [4][4];
  logic [31:0] br  [4][4];

  function automatic logic [31:0] a_in(int i, int j);
    return (j == 0) ? a_edge[i*32 +: 32] : ar[i][j-1];
  endfunction

  function automatic logic [31:0] b_in(int i, int j);
    return (i == 0) ? b_edge[j*32 +: 32] : br[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (pe_clr) begin
          acc[i][j] <= '0;
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + a_in(i, j) * b_in(i, j);
          ar[i][j]  <= a_in(i, j);
          br[i][j]  <= b_in(i, j);
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] ma    [16];
  logic [31:0] mb    [16];
  logic [31:0] exp_c [16];

  task automatic compute_exp();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) s = s + ma[i*4+k] * mb[k*4+j];
        exp_c[i*4+j] = s;
      end
    end
  endtask

  task automatic load_word(input int addr, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr  = 5'(addr);
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic load_mats();
    for (int k = 0; k < 16; k++) begin
      load_word(k, ma[k]);
      load_word(16 + k, mb[k]);
    end
  endtask

  // Called at cycle cyc0 after the start-sampling cycle; waits for done.
  task automatic finish_run(input int cyc0, input string nm);
    int c;
    c = cyc0;
    while (done !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    check({nm, "_done_cycle"}, 32'(c), 32'd16);
    check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_C%0d", nm, i), acc[i/4][i%4], exp_c[i]);
    end
  endtask

  typedef struct {
    int               t;
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
  } vec_t;

  function automatic vec_t mk(int t, int a0, int a1, int a2, int a3,
                              int b0, int b1, int b2, int b3);
    vec_t v;
    v.t = t;
    v.a[0] = 32'(a0); v.a[1] = 32'(a1); v.a[2] = 32'(a2); v.a[3] = 32'(a3);
    v.b[0] = 32'(b0); v.b[1] = 32'(b1); v.b[2] = 32'(b2); v.b[3] = 32'(b3);
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    int cur;
    int n_done;

    // A[r][c]=10r+c, B[r][c]=100+10r+c: lane i = A[i][t-i], lane j = B[t-j][j]
    tbl[0] = mk(0, 0, 0, 0, 0,     100, 0, 0, 0);
    tbl[1] = mk(1, 1, 10, 0, 0,    110, 101, 0, 0);
    tbl[2] = mk(2, 2, 11, 20, 0,   120, 111, 102, 0);
    tbl[3] = mk(3, 3, 12, 21, 30,  130, 121, 112, 103);
    tbl[4] = mk(4, 0, 13, 22, 31,  0, 131, 122, 113);
    tbl[5] = mk(5, 0, 0, 23, 32,   0, 0, 132, 123);
    tbl[6] = mk(6, 0, 0, 0, 33,    0, 0, 0, 133);
    tbl[7] = mk(7, 0, 0, 0, 0,     0, 0, 0, 0);
    tbl[8] = mk(8, 0, 0, 0, 0,     0, 0, 0, 0);
    tbl[9] = mk(9, 0, 0, 0, 0,     0, 0, 0, 0);

    rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;

    // Reset state
    tick();
    check("rst_pe_clr", 32'(pe_clr), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_a_edge_zero", 32'(a_edge != '0), 32'd0);
    check("rst_b_edge_zero", 32'(b_edge != '0), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ld_ready", 32'(ld_ready), 32'd1);
    check("post_rst_pe_clr", 32'(pe_clr), 32'd0);

    // Identity A, B = 1..16: latency, busy window, results equal B
    for (int k = 0; k < 16; k++) begin
      ma[k] = (k / 4 == k % 4) ? 32'd1 : 32'd0;
      mb[k] = 32'(k + 1);
    end
    load_mats();
    compute_exp();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ident_pe_clr_clear", 32'(pe_clr), 32'd1);
    check("ident_ld_ready_busy", 32'(ld_ready), 32'd0);
    for (int c = 1; c < 16; c++) begin
      check($sformatf("ident_busy_c%0d", c), 32'(busy), 32'd1);
      check($sformatf("ident_done_c%0d", c), 32'(done), 32'd0);
      tick();
    end
    finish_run(16, "ident");
    tick();
    check("ident_done_pulse_len", 32'(done), 32'd0);

    // Feed skew, table-driven
    for (int k = 0; k < 16; k++) begin
      ma[k] = 32'(10 * (k / 4) + k % 4);
      mb[k] = 32'(100 + 10 * (k / 4) + k % 4);
    end
    load_mats();
    compute_exp();
    start = 1'b1;
    tick();
    start = 1'b0;
    cur = 1;
    check("skew_clear_a_zero", 32'(a_edge != '0), 32'd0);
    for (int k = 0; k < 10; k++) begin
      while (cur < 2 + tbl[k].t) begin
        tick();
        cur++;
      end
      for (int i = 0; i < 4; i++) begin
        check($sformatf("skew_t%0d_a%0d", tbl[k].t, i), a_edge[i*32 +: 32], tbl[k].a[i]);
        check($sformatf("skew_t%0d_b%0d", tbl[k].t, i), b_edge[i*32 +: 32], tbl[k].b[i]);
      end
    end
    tick();
    cur++;
    check("skew_drain_a_zero", 32'(a_edge != '0), 32'd0);
    check("skew_drain_busy", 32'(busy), 32'd1);
    finish_run(cur, "skew");
    tick();

    // start and a load held during a run: ignored
    start = 1'b1;
    tick();
    ld_valid = 1'b1;
    ld_addr  = 5'd0;
    ld_data  = 32'hDEAD;
    for (int c = 1; c < 16; c++) begin
      if (c == 3 || c == 9) begin
        check($sformatf("hold_ld_ready_c%0d", c), 32'(ld_ready), 32'd0);
      end
      tick();
    end
    finish_run(16, "hold");
    start    = 1'b0;
    ld_valid = 1'b0;
    tick();
    check("hold_no_restart", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rerun_a00_kept", a_edge[31:0], 32'd0);
    check("rerun_b00", b_edge[31:0], 32'd100);
    finish_run(2, "rerun");
    tick();

    // Reset at FEED t=5
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    check("abort_t5_a2", a_edge[64 +: 32], 32'd23);
    rst = 1'b1;
    #1;
    check("abort_pe_clr_in_rst", 32'(pe_clr), 32'd1);
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_a_zero", 32'(a_edge != '0), 32'd0);
    check("abort_b_zero", 32'(b_edge != '0), 32'd0);
    check("abort_pe_clr", 32'(pe_clr), 32'd1);
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_idle_ready", 32'(ld_ready), 32'd1);
    for (int k = 0; k < 16; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end
    compute_exp();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    check("cleared_a_t3", 32'(a_edge != '0), 32'd0);
    check("cleared_b_t3", 32'(b_edge != '0), 32'd0);
    finish_run(5, "zero");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back runs
    for (int k = 0; k < 16; k++) begin
      ma[k] = (k / 4 == k % 4) ? 32'd1 : 32'd0;
      mb[k] = 32'(k + 1);
    end
    load_mats();
    compute_exp();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_run(1, "b2b1");
    start = 1'b1;
    tick();
    check("b2b_idle_gap", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    check("b2b_restart", 32'(busy), 32'd1);
    finish_run(1, "b2b2");
    tick();
`ifdef SYSMM_RUN_CNT_EN
    check("run_cnt_two", 32'(run_cnt), 32'd2);
`endif

    // Load of B[3][3] in the same cycle as start
    ld_valid = 1'b1;
    ld_addr  = 5'd31;
    ld_data  = 32'd7;
    start    = 1'b1;
    tick();
    ld_valid = 1'b0;
    start    = 1'b0;
    mb[15] = 32'd7;
    compute_exp();
    for (int c = 1; c < 8; c++) tick();
    check("ldst_b3_t6", b_edge[96 +: 32], 32'd7);
    check("ldst_a3_t6", a_edge[96 +: 32], 32'd1);
    finish_run(8, "ldst");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
